// File: rtl/reg_bank_write_arbiter.sv
// Write arbiter and sequencer for a small shared register bank, with a combinational read port.
// Selection is round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-first selection.
module reg_bank_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int                 IDX_W   = $clog2(NUM_REQ);
    localparam int                 DEPTH   = 1 << ADDR_W;
    localparam logic [NUM_REQ-1:0] ONE_REQ = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] gnt_nx_s;
    logic [NUM_REQ-1:0] ack_r;
    logic [NUM_REQ-1:0] ack_nx_s;
    logic               busy_r;
    logic               busy_nx_s;
    logic [IDX_W-1:0]   win_r;
    logic [IDX_W-1:0]   win_nx_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   rr_ptr_nx_s;
    logic [ADDR_W-1:0]  lat_addr_r;
    logic [ADDR_W-1:0]  lat_addr_nx_s;
    logic [DATA_W-1:0]  lat_data_r;
    logic [DATA_W-1:0]  lat_data_nx_s;
    logic [NUM_REQ-1:0] sel_req_s;
    logic [IDX_W-1:0]   sel_start_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               bank_we_s;
    logic [DATA_W-1:0]  bank_r [DEPTH];
    logic [ADDR_W-1:0]  addr_a_s [NUM_REQ];
    logic [DATA_W-1:0]  data_a_s [NUM_REQ];
`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   ptr_after_win_s;
`endif

    // Returns {found, index} of the first set bit scanning upward from start, wrapping.
    function automatic logic [IDX_W:0] pick_first(input logic [NUM_REQ-1:0] req_v,
                                                  input logic [IDX_W-1:0]   start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] pos;
        res = {(IDX_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(start) + k) % NUM_REQ);
            if (req_v[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a_s[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a_s[i] = req_data[i*DATA_W +: DATA_W];
    end

`ifndef ARB_FIXED_PRIO_EN
    assign ptr_after_win_s = (win_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_r + IDX_W'(1);
`endif

    // Candidate set and scan origin; the write cycle excludes the current winner.
    always_comb begin
        sel_req_s   = req;
        sel_start_s = rr_ptr_r;
        if (state_r == ST_WRITE) begin
            sel_req_s = req & ~(ONE_REQ << win_r);
`ifdef ARB_FIXED_PRIO_EN
            sel_start_s = {IDX_W{1'b0}};
`else
            sel_start_s = ptr_after_win_s;
`endif
        end else begin
            sel_req_s   = req;
            sel_start_s = rr_ptr_r;
        end
        {sel_found_s, sel_idx_s} = pick_first(sel_req_s, sel_start_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_nx_s = ST_GRANT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GRANT: state_nx_s = ST_WRITE;
            ST_WRITE: begin
                if (sel_found_s) begin
                    state_nx_s = ST_GRANT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of grant, ack, latched request and pointer, plus the bank write strobe.
    always_comb begin
        gnt_nx_s      = {NUM_REQ{1'b0}};
        ack_nx_s      = {NUM_REQ{1'b0}};
        win_nx_s      = win_r;
        lat_addr_nx_s = lat_addr_r;
        lat_data_nx_s = lat_data_r;
        rr_ptr_nx_s   = rr_ptr_r;
        bank_we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    gnt_nx_s      = ONE_REQ << sel_idx_s;
                    win_nx_s      = sel_idx_s;
                    lat_addr_nx_s = addr_a_s[sel_idx_s];
                    lat_data_nx_s = data_a_s[sel_idx_s];
                end else begin
                    gnt_nx_s = {NUM_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                gnt_nx_s = gnt_r;
            end
            ST_WRITE: begin
                bank_we_s = 1'b1;
                ack_nx_s  = gnt_r;
`ifdef ARB_FIXED_PRIO_EN
                rr_ptr_nx_s = {IDX_W{1'b0}};
`else
                rr_ptr_nx_s = ptr_after_win_s;
`endif
                if (sel_found_s) begin
                    gnt_nx_s      = ONE_REQ << sel_idx_s;
                    win_nx_s      = sel_idx_s;
                    lat_addr_nx_s = addr_a_s[sel_idx_s];
                    lat_data_nx_s = data_a_s[sel_idx_s];
                end else begin
                    gnt_nx_s = {NUM_REQ{1'b0}};
                end
            end
            default: begin
                gnt_nx_s = {NUM_REQ{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // Registered outputs and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r      <= {NUM_REQ{1'b0}};
            ack_r      <= {NUM_REQ{1'b0}};
            busy_r     <= 1'b0;
            win_r      <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            lat_addr_r <= {ADDR_W{1'b0}};
            lat_data_r <= {DATA_W{1'b0}};
        end else begin
            gnt_r      <= gnt_nx_s;
            ack_r      <= ack_nx_s;
            busy_r     <= busy_nx_s;
            win_r      <= win_nx_s;
            rr_ptr_r   <= rr_ptr_nx_s;
            lat_addr_r <= lat_addr_nx_s;
            lat_data_r <= lat_data_nx_s;
        end
    end

    // Register bank; reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bank_we_s) begin
            bank_r[lat_addr_r] <= lat_data_r;
        end
    end

    assign gnt     = gnt_r;
    assign ack     = ack_r;
    assign busy    = busy_r;
    assign rd_data = bank_r[rd_addr];

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Randomized self-checking bench for reg_bank_write_arbiter against a transaction-level model.
module tb_reg_bank_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 4;

    logic                      clk      = 1'b0;
    logic                      reset    = 1'b1;
    logic [NUM_REQ-1:0]        req      = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [ADDR_W-1:0]         rd_addr  = '0;
    logic [DATA_W-1:0]         rd_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: one in-flight write (two cycles after selection), its ack, the pointer, the bank.
    logic              m_active = 1'b0;
    int                m_age    = 0;
    int                m_win    = 0;
    int                m_ptr    = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_data   = '0;
    logic [NUM_REQ-1:0] m_ack   = '0;
    logic [DATA_W-1:0] m_bank [DEPTH];

`ifdef ARB_FIXED_PRIO_EN
    int order [5] = '{0, 1, 0, 1, 0};
`else
    int order [5] = '{0, 1, 2, 3, 0};
`endif

    reg_bank_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: snapshot inputs, advance the model over the edge, compare outputs just after it.
    task automatic tick();
        logic [NUM_REQ-1:0]        rq;
        logic [NUM_REQ*ADDR_W-1:0] ad;
        logic [NUM_REQ*DATA_W-1:0] dt;
        logic                      rs;
        int                        excl;
        logic                      sel;
        logic                      found;
        rq = req;
        ad = req_addr;
        dt = req_data;
        rs = reset;
        @(posedge clk);
        if (rs) begin
            m_active = 1'b0;
            m_age    = 0;
            m_win    = 0;
            m_ptr    = 0;
            m_ack    = '0;
            for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
        end else begin
            excl  = -1;
            sel   = 1'b0;
            m_ack = '0;
            if (m_active && m_age == 2) begin
                m_bank[m_addr] = m_data;
                m_ack    = NUM_REQ'(1) << m_win;
                m_active = 1'b0;
                excl     = m_win;
`ifndef ARB_FIXED_PRIO_EN
                m_ptr = (m_win + 1) % NUM_REQ;
`endif
                sel = 1'b1;
            end else if (m_active) begin
                m_age = 2;
            end else begin
                sel = 1'b1;
            end
            if (sel) begin
                found = 1'b0;
                for (int j = 0; j < NUM_REQ; j++) begin
                    int i;
                    i = (m_ptr + j) % NUM_REQ;
                    if (!found && rq[i] && i != excl) begin
                        found    = 1'b1;
                        m_active = 1'b1;
                        m_age    = 1;
                        m_win    = i;
                        m_addr   = ad[i*ADDR_W +: ADDR_W];
                        m_data   = dt[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
        #1;
        check("gnt", gnt, m_active ? (32'd1 << m_win) : 32'd0);
        check("ack", ack, m_ack);
        check("busy", busy, m_active);
        check("rd_data", rd_data, m_bank[rd_addr]);
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        check("ack_onehot", ($countones(ack) <= 1), 1);
    endtask

    task automatic sweep_bank();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = a[ADDR_W-1:0];
            #1;
            check("bank_sweep", rd_data, m_bank[a]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
        do_reset();
        check("reset_gnt", gnt, 0);
        check("reset_busy", busy, 0);

        // Single write: grant at cycle 1, ack and new read data at cycle 3.
        rd_addr = 2'd2;
        set_req(0, 2'd2, 8'hA5);
        req = 4'b0001;
        tick();
        check("t1_gnt_c1", gnt, 4'b0001);
        check("t1_busy_c1", busy, 1);
        tick();
        tick();
        check("t1_ack_c3", ack, 4'b0001);
        check("t1_rd_c3", rd_data, 8'hA5);
        check("t1_busy_c3", busy, 0);
        req = 4'b0000;
        tick();
        tick();

        // All requesters pending: back-to-back grants every two cycles.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i[ADDR_W-1:0], 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_gnt_order", gnt, 32'd1 << order[k]);
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
`ifndef ARB_FIXED_PRIO_EN
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = a[ADDR_W-1:0];
            #1;
            check("t2_bank", rd_data, 32'(8'h10 + a));
        end
`endif
        sweep_bank();

        // Pointer past requester 1: requester 0 wins first, then 1.
        do_reset();
        set_req(1, 2'd1, 8'h21);
        req = 4'b0010;
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        set_req(0, 2'd0, 8'h20);
        req = 4'b0011;
        tick();
        check("t3_first", gnt, 4'b0001);
        tick();
        tick();
        check("t3_second", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        tick();
        tick();

        // Data changed after selection does not reach the bank.
        do_reset();
        rd_addr = 2'd3;
        set_req(0, 2'd3, 8'h33);
        req = 4'b0001;
        tick();
        set_req(0, 2'd3, 8'hCC);
        tick();
        tick();
        check("t4_ack", ack, 4'b0001);
        check("t4_latched", rd_data, 8'h33);
        req = 4'b0000;
        tick();

        // Reset during the write cycle cancels the write and its ack.
        do_reset();
        rd_addr = 2'd1;
        set_req(0, 2'd1, 8'hFF);
        req = 4'b0001;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_bank", rd_data, 8'h00);
        check("t5_gnt", gnt, 4'b0000);
        check("t5_ack", ack, 4'b0000);
        check("t5_busy", busy, 0);
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        check("t5_no_ack", ack, 4'b0000);
        check("t5_bank_after", rd_data, 8'h00);

        // Lone continuous requester is re-granted through idle every three cycles.
        do_reset();
        set_req(3, 2'd0, 8'h5A);
        req = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_gnt", gnt, 4'b1000);
            tick();
            tick();
            check("t6_ack", ack, 4'b1000);
        end
        req = 4'b0000;
        tick();
        tick();

        // Random traffic with level requests, early drops, data churn and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
                        end else begin
                            req[i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 39) == 0) begin
                        req[i] = 1'b0;
                    end else if ($urandom_range(0, 4) == 0) begin
                        set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
                end
            end
            reset   = ($urandom_range(0, 299) == 0);
            rd_addr = ADDR_W'($urandom);
            tick();
            if (c % 100 == 99) sweep_bank();
        end
        reset = 1'b0;
        req   = '0;
        tick();
        tick();
        tick();
        sweep_bank();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
Round-robin arbiter and write sequencer for a small bank of positive-edge D flip-flop registers that several requesters share. Each cycle it picks one pending requester, latches that requester's address and data, performs one write into the bank, and acknowledges the winner. It sits between the lab's switch/requester logic and the storage bank, and exposes a combinational read port for display on LEDR.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, register word width
ADDR_W, 2, bank address width; bank depth = 2**ADDR_W

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request, level
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  flattened data; requester i at [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, registered
ack  output  NUM_REQ  one-hot single-cycle write-done pulse, registered
busy  output  1  high when the FSM is not in IDLE
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  bank[rd_addr], combinational

Behaviour:
- Reset: all bank words=0, gnt=0, ack=0, busy=0, state=IDLE, rr_ptr=0. Reset overrides all other activity, including a write in progress; no partial write occurs.
- State machine:
  - IDLE: if any req bit is set, select a winner, set gnt[winner]=1, latch req_addr/req_data of the winner into internal registers, then go to GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle): gnt held. Next state is WRITE.
  - WRITE (1 cycle): bank[latched_addr] <= latched_data. ack[winner]=1 during the following cycle. gnt cleared. rr_ptr <= (winner+1) mod NUM_REQ. Then:
    - If any req other than the winner's is set, select the next winner immediately and go to GRANT (back-to-back).
    - Otherwise go to IDLE.
- Winner selection: first set bit of req searching rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ. Selection is fair: no requester waits more than NUM_REQ-1 grants.
- Latency: req rising in IDLE at cycle 0 gives gnt at cycle 1, the bank write at the end of cycle 2, ack at cycle 3, and rd_data reflecting the new value from cycle 3.
- Data stability: address/data are sampled only at the selection edge. Changes to req_addr/req_data after that edge do not affect the write.
- Handshake: a requester keeps req high until it sees ack. If req drops before ack, the write still completes and is acknowledged.
- Re-request: the winner is excluded from the back-to-back selection in WRITE, so it cannot win twice in a row while another requester is pending.
- Read/write collision: rd_addr equal to the address being written returns the old value until the write edge, then the new value. There is no bypass.
- busy = (state != IDLE). At most one gnt bit and one ack bit are ever set.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: winner selection becomes fixed priority, lowest index wins. rr_ptr is not used and stays 0. The back-to-back exclusion of the previous winner is kept, so requester 0 cannot monopolise consecutive cycles while others are pending.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset, then req=4'b0001, req_addr[0]=2, req_data[0]=8'hA5 -> gnt=0001 at cycle 1, ack=0001 at cycle 3, rd_addr=2 gives rd_data=A5, busy back to 0 at cycle 3.
2. req=4'b1111 held, all requesters writing distinct addresses with data 8'h10+i -> grants in order 0,1,2,3,0 with GRANT/WRITE back-to-back (gnt every 2 cycles), bank[i]=10+i.
3. rr_ptr=2 (after requester 1 wins), then req=4'b0011 -> requester 0 granted before 1. With ARB_FIXED_PRIO_EN, the same case grants 0, then 1.
4. Change req_data[winner] from 8'h33 to 8'hCC during GRANT -> bank holds 33.
5. Assert reset during WRITE with data 8'hFF to address 1 -> bank[1]=0, gnt=0, ack=0, busy=0 on the next cycle, and no ack is issued.
6. Only requester 3 requests continuously -> it is re-granted via IDLE every 3 cycles; gnt is never two bits and ack is never two bits.
